// File: rtl/toggle_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : toggle_monitor_if
// Description : Event-line and status bundle for toggle_monitor. The slave
//               modport is the monitor's view; the master modport is the
//               view of whoever drives the toggle line and reads status.
// Revision    : 1.0 - initial release
// ============================================================================
interface toggle_monitor_if #(
  parameter int CNT_W = 8
);
  logic             tog_in;
  logic             clear;
  logic             event_pulse;
  logic [CNT_W-1:0] event_count;
  logic             overflow;
  logic             stalled;
  logic             running;

  modport slave (
    input  tog_in,
    input  clear,
    output event_pulse,
    output event_count,
    output overflow,
    output stalled,
    output running
  );

  modport master (
    output tog_in,
    output clear,
    input  event_pulse,
    input  event_count,
    input  overflow,
    input  stalled,
    input  running
  );
endinterface
`default_nettype wire

// File: rtl/toggle_monitor.sv
`default_nettype none
// ============================================================================
// Module      : toggle_monitor
// Description : Receives a toggle-encoded event line from an unrelated clock
//               domain, synchronizes it, emits one pulse per inversion, keeps
//               a wrapping event count with sticky overflow and runs a
//               watchdog that flags a stalled source.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_monitor #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire               clka,
  input  wire               reset,
  toggle_monitor_if.slave   bus
);

  // Timer only needs to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_WAIT_FIRST = 2'd0;
  localparam logic [1:0] S_RUN        = 2'd1;
  localparam logic [1:0] S_STALL      = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;
  logic [TW-1:0]          r_timer;
  logic [1:0]             r_state;

  logic                   w_sync;
  logic                   w_event;

  assign w_sync = r_sync[SYNC_STAGES-1];
  // A pending inversion is dropped when clear is asserted in the same cycle.
  assign w_event = (w_sync != r_ref) && !bus.clear;

  // Synchronizer chain; deliberately untouched by clear so the line level
  // seen after clear is still the true, settled one.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.tog_in};
    end
  end

  // Edge detection against the last accepted level, plus counter/overflow.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      r_ref   <= 1'b0;
      r_pulse <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.clear) begin
      r_ref   <= w_sync;
      r_pulse <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pulse <= w_event;
      if (w_event) begin
        r_ref   <= w_sync;
        r_count <= r_count + CNT_W'(1);
        if (&r_count) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // Watchdog state machine; an event always wins over a same-cycle timeout.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT_FIRST;
      r_timer <= '0;
    end else if (bus.clear) begin
      r_state <= S_WAIT_FIRST;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_WAIT_FIRST: begin
          if (w_event) begin
            r_state <= S_RUN;
            r_timer <= '0;
          end
        end
        S_RUN: begin
          if (w_event) begin
            r_timer <= '0;
          end else if (r_timer == C_TIMER_LAST) begin
            r_state <= S_STALL;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STALL: begin
          if (w_event) begin
            r_state <= S_RUN;
            r_timer <= '0;
          end
        end
        default: begin
          r_state <= S_WAIT_FIRST;
          r_timer <= '0;
        end
      endcase
    end
  end

  // All outputs come straight from flops.
  assign bus.event_pulse = r_pulse;
  assign bus.event_count = r_count;
  assign bus.overflow    = r_ovf;
  assign bus.stalled     = (r_state == S_STALL);
  assign bus.running     = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_toggle_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_monitor
// Description : Self-checking bench for toggle_monitor (CNT_W=3, TIMEOUT=16,
//               SYNC_STAGES=2) with a pulse scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_monitor;

  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 16;
  localparam int MASK    = (1 << CNT_W) - 1;
  // Drive after edge d -> captured at d+1 -> pulse visible in cycle d+3.
  localparam int LAT     = 3;

  typedef struct {
    int cyc;
    int cnt;
    int ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   exp_count;
  int   exp_ovf;
  exp_t sb_q[$];

  toggle_monitor_if #(.CNT_W(CNT_W)) bus ();

  toggle_monitor #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (2)
  ) dut (
    .clka  (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every observed pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && bus.event_pulse) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_count", bus.event_count, e.cnt);
        chk("pulse_ovf", bus.overflow, e.ovf);
      end
    end
  end

  task automatic toggle();
    exp_t e;
    @(posedge clk);
    #1;
    bus.tog_in = ~bus.tog_in;
    if (exp_count == MASK) exp_ovf = 1;
    exp_count = (exp_count + 1) & MASK;
    e.cyc = cyc + LAT;
    e.cnt = exp_count;
    e.ovf = exp_ovf;
    sb_q.push_back(e);
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    exp_count = 0;
    exp_ovf   = 0;
  endtask

  // Inversion reaches the synchronizer output exactly when clear is high.
  task automatic flip_with_clear();
    @(posedge clk);
    #1;
    bus.tog_in = ~bus.tog_in;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    exp_count = 0;
    exp_ovf   = 0;
  endtask

  task automatic chk_status(input string tag, input int cnt, input int ovf,
                            input int run, input int stl);
    chk({tag, "_count"}, bus.event_count, cnt);
    chk({tag, "_ovf"}, bus.overflow, ovf);
    chk({tag, "_running"}, bus.running, run);
    chk({tag, "_stalled"}, bus.stalled, stl);
  endtask

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 0;
    exp_ovf   = 0;
    rst        = 1'b1;
    bus.tog_in = 1'b0;
    bus.clear  = 1'b0;

    // Reset state and idle in WAIT_FIRST.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", bus.event_pulse, 0);
    chk_status("rst", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("idle_pulse", bus.event_pulse, 0);
    chk_status("idle", 0, 0, 0, 0);

    // Three events, 5 cycles apart.
    for (int i = 0; i < 3; i++) begin
      toggle();
      repeat (4) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    chk_status("three", 3, 0, 1, 0);

    // Watchdog: stall exactly TIMEOUT edges after the pulse edge.
    toggle();
    repeat (LAT + TIMEOUT) @(negedge clk);
    chk("pre_stall_stalled", bus.stalled, 0);
    chk("pre_stall_running", bus.running, 1);
    @(negedge clk);
    chk("stall_stalled", bus.stalled, 1);
    chk("stall_running", bus.running, 0);
    toggle();
    repeat (5) @(posedge clk);
    #1;
    chk_status("resume", 5, 0, 1, 0);

    // Wrap and sticky overflow.
    do_clear();
    chk_status("clr1", 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      toggle();
      repeat (2) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #1;
    chk_status("wrap", 1, 1, 1, 0);
    do_clear();
    chk_status("clr2", 0, 0, 0, 0);

    // Clear colliding with a synchronized inversion.
    flip_with_clear();
    repeat (6) @(posedge clk);
    #1;
    chk("coll_pulse", bus.event_pulse, 0);
    chk_status("coll", 0, 0, 0, 0);

    // Async reset mid-RUN with count 5 and tog_in high.
    if (bus.tog_in) flip_with_clear();
    for (int i = 0; i < 5; i++) begin
      toggle();
      repeat (2) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    chk("pre_rst_tog", bus.tog_in, 1);
    chk_status("pre_rst", 5, 0, 1, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_pulse", bus.event_pulse, 0);
    chk_status("async_rst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_count = 0;
    exp_ovf   = 0;
    begin
      exp_t e;
      exp_count = 1;
      e.cyc = cyc + LAT;
      e.cnt = 1;
      e.ovf = 0;
      sb_q.push_back(e);
    end
    repeat (6) @(posedge clk);
    #1;
    chk_status("post_rst", 1, 0, 1, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/toggle_monitor.md
# toggle_monitor

Receive-side counterpart to the toggle-flop event source: takes a toggle-encoded event line (level inverts once per event, resets low), synchronizes it into the local `clka` domain, and converts each inversion into a one-cycle pulse. It keeps a wrapping event counter with a sticky overflow flag and runs a watchdog that flags a stalled source. It sits beside any toggle source whose clock is unrelated to `clka`.

## Interface
- `CNT_W`, default 8: event counter width (>= 1).
- `TIMEOUT`, default 16: cycles without an event in RUN before STALL (>= 2).
- `SYNC_STAGES`, default 2: synchronizer flops on `tog_in` (>= 2).

Ports:
- `clka`  input  1  clock; all state on its rising edge.
- `reset`  input  1  asynchronous, active-high reset; one clock domain, no other resets.
- `tog_in`  input  1  toggle-encoded event line, asynchronous to `clka`.
- `clear`  input  1  synchronous clear of count, overflow, watchdog and state.
- `event_pulse`  output  1  high for exactly one cycle per detected inversion.
- `event_count`  output  CNT_W  events since reset/clear, wraps.
- `overflow`  output  1  sticky; set when `event_count` wraps.
- `stalled`  output  1  high while in STALL.
- `running`  output  1  high while in RUN.

## Operation
- Synchronizer: `tog_in` -> `SYNC_STAGES` flops -> `sync`; all reset to 0.
- Reference register `ref` (reset 0) holds last accepted level; event = (`sync` != `ref`) and not `clear`; on event `ref` <= `sync`.
- On event: `event_pulse` <= 1, `event_count` <= `event_count`+1 mod 2^CNT_W; if old count was all ones, `overflow` <= 1 (sticky until reset/clear).
- Back-to-back inversions on consecutive `sync` samples give consecutive pulses; inversions faster than one per `clka` cycle are not guaranteed to be counted.
- States: WAIT_FIRST (reset/clear; watchdog idle), RUN, STALL.
  - WAIT_FIRST -> RUN on first event.
  - RUN: watchdog `timer` clears to 0 on event, else increments; at `timer` == TIMEOUT-1 with no event -> STALL.
  - STALL -> RUN on event (pulse and count as usual, `timer` <= 0).
- Event and timeout in same cycle: event wins, stay RUN.
- `clear`: `event_count` <= 0, `overflow` <= 0, `timer` <= 0, state <= WAIT_FIRST, `event_pulse` <= 0, `ref` <= `sync`. Any pending event that cycle is discarded. Synchronizer chain is not cleared.
- `reset` mid-operation: all flops and outputs go to 0 and state to WAIT_FIRST immediately, independent of `clka`. If `tog_in` is high after release, one event is counted, which is intentional: the source resets low.

## Timing
- Reset values: `event_pulse`=0, `event_count`=0, `overflow`=0, `stalled`=0, `running`=0.
- Latency: a `tog_in` change captured by the first sync flop at edge E0 gives `event_pulse`, the count update and the state change registered at edge E(SYNC_STAGES). For the default, that is 2 edges after capture.
- `stalled` rises exactly TIMEOUT edges after the edge that registered the last event pulse, if no further event arrives.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then release with `tog_in`=0, idle 40 cycles -> no pulse, `event_count`=0, `running`=0, `stalled`=0 (watchdog inactive in WAIT_FIRST).
- Toggle `tog_in` 3 times, 5 cycles apart -> 3 single-cycle pulses, each 2 edges after capture; `event_count`=3; `running`=1.
- One toggle, then idle -> `stalled`=1 exactly 16 edges after the pulse edge; the next toggle gives a pulse, `stalled`=0, `running`=1.
- CNT_W=3, 9 toggles -> count sequence 1..7,0,1; `overflow` rises on the 8th event and stays 1; `clear` -> count 0, `overflow` 0, WAIT_FIRST.
- Assert `clear` in the same cycle a synchronized inversion arrives -> no pulse, count 0, and no phantom event on the following cycle.
- Assert `reset` mid-RUN with count 5 and `tog_in`=1 -> outputs are 0 before the next `clka` edge; after release one event is counted (`event_count`=1).
